alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 117 +++++++++++
 tb/tb_alu_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one combinational ALU
// Accepts one operation at a time and returns its result with a ready/valid response handshake.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_c,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_id,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [4:0] MAX_OP = 5'd6;

    state_t      state_q;
    logic        last_grant_q;
    logic        err_q;
    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    logic [4:0]  alu_op_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic        resp_id_q;
    logic        resp_err_q;

    logic        grant0;
    logic        grant1;
    logic        in_idle;
    logic        accept;
    logic [4:0]  sel_op;
    logic        sel_illegal;

    // Under contention, requester 0 wins unless round-robin says it went last.
    always_comb begin
        grant0      = req0_valid && (!req1_valid || !RR_EN || last_grant_q);
        grant1      = req1_valid && !grant0;
        in_idle     = (state_q == IDLE) && !rst;
        req0_ready  = in_idle && grant0;
        req1_ready  = in_idle && grant1;
        accept      = req0_ready || req1_ready;
        sel_op      = grant1 ? req1_op : req0_op;
        sel_illegal = sel_op > MAX_OP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_a_q      <= grant1 ? req1_a : req0_a;
                        alu_b_q      <= grant1 ? req1_b : req0_b;
                        alu_op_q     <= sel_illegal ? 5'd0 : sel_op;
                        err_q        <= sel_illegal;
                        last_grant_q <= grant1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data_q  <= err_q ? 32'd0 : alu_c;
                    resp_id_q    <= last_grant_q;
                    resp_err_q   <= err_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
// Vector table, hand sequences for contention/backpressure/reset, then random traffic vs a transaction model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [4:0]  alu_op;
    logic        resp_valid, resp_ready, resp_id, resp_err;
    logic [31:0] resp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        case (op)
            5'd0, 5'd1: return a + b;
            5'd2:       return a - b;
            5'd3:       return a & b;
            5'd4:       return a | b;
            5'd5:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd6:       return {b[15:0], 16'h0000};
            default:    return 32'd0;
        endcase
    endfunction

    assign alu_c = ref_alu(alu_a, alu_b, alu_op);

    alu_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_err(resp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; runs one request through to its handshake.
    task automatic do_txn(input int who, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input logic exp_e, input string nm);
        if (who == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
        else          begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
        #1;
        chk({nm, "_ready"}, 32'((who == 0) ? req0_ready : req1_ready), 32'd1);
        chk({nm, "_other_ready"}, 32'((who == 0) ? req1_ready : req0_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk({nm, "_exec_alu_a"}, alu_a, a);
        chk({nm, "_exec_alu_b"}, alu_b, b);
        chk({nm, "_exec_alu_op"}, 32'(alu_op), 32'((op > 5'd6) ? 5'd0 : op));
        chk({nm, "_exec_rv"}, 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_rv"}, 32'(resp_valid), 32'd1);
        chk({nm, "_data"}, resp_data, exp_d);
        chk({nm, "_id"}, 32'(resp_id), 32'(who));
        chk({nm, "_err"}, 32'(resp_err), 32'(exp_e));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({nm, "_done_rv"}, 32'(resp_valid), 32'd0);
    endtask

    typedef struct {
        int          who;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vt[10];

    initial begin
        int          grants[$];
        logic [31:0] rdata[$];
        logic        rid[$];
        bit          busy, m_last, m_err, m_id, d_rst, d_v0, d_v1, d_rr;
        int          e, acc_e, winner;
        logic [31:0] m_data, d_a0, d_b0, d_a1, d_b1;
        logic [4:0]  d_op0, d_op1, m_op;

        vt[0] = '{0, 5'd1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0};
        vt[1] = '{1, 5'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        vt[2] = '{0, 5'd6, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000, 1'b0};
        vt[3] = '{1, 5'd7, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1};
        vt[4] = '{0, 5'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0};
        vt[5] = '{1, 5'd2, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0};
        vt[6] = '{0, 5'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0};
        vt[7] = '{1, 5'd4, 32'hA000_0000, 32'h0000_000B, 32'hA000_000B, 1'b0};
        vt[8] = '{0, 5'd5, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vt[9] = '{1, 5'd31, 32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 1'b1};

        // Reset state, with both requesters asserting valid during reset.
        clear_inputs();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_rv", 32'(resp_valid), 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_id_err", {30'd0, resp_id, resp_err}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);

        foreach (vt[i]) do_txn(vt[i].who, vt[i].op, vt[i].a, vt[i].b, vt[i].exp_d, vt[i].exp_e, $sformatf("vec%0d", i));

        // Contention straight out of reset: requester 0 must win first.
        do_reset();
        req0_valid = 1'b1; req0_op = 5'd2; req0_a = 32'd10;   req0_b = 32'd4;
        req1_valid = 1'b1; req1_op = 5'd4; req1_a = 32'hF0;   req1_b = 32'h0F;
        resp_ready = 1'b1;
        for (int c = 0; c < 40 && (grants.size() < 3 || rdata.size() < 2); c++) begin
            #1;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (resp_valid) begin rdata.push_back(resp_data); rid.push_back(resp_id); end
            @(negedge clk);
        end
        chk("cont_ngrants", 32'(grants.size()), 32'd3);
        chk("cont_nresp", 32'(rdata.size()), 32'd2);
        if (grants.size() >= 3) begin
            chk("cont_g0", 32'(grants[0]), 32'd0);
            chk("cont_g1", 32'(grants[1]), 32'd1);
            chk("cont_g2", 32'(grants[2]), 32'd0);
        end
        if (rdata.size() >= 2) begin
            chk("cont_r0", rdata[0], 32'h6);
            chk("cont_r0_id", 32'(rid[0]), 32'd0);
            chk("cont_r1", rdata[1], 32'hFF);
            chk("cont_r1_id", 32'(rid[1]), 32'd1);
        end

        // Backpressure with requester 1 waiting the whole time.
        do_reset();
        req0_valid = 1'b1; req0_op = 5'd1; req0_a = 32'd7; req0_b = 32'd8;
        req1_valid = 1'b1; req1_op = 5'd3; req1_a = 32'h3; req1_b = 32'h5;
        #1;
        chk("bp_ready0", 32'(req0_ready), 32'd1);
        chk("bp_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("bp_exec_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("bp_hold%0d_rv", c), 32'(resp_valid), 32'd1);
            chk($sformatf("bp_hold%0d_data", c), resp_data, 32'd15);
            chk($sformatf("bp_hold%0d_ready1", c), 32'(req1_ready), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        chk("bp_after_rv", 32'(resp_valid), 32'd0);
        chk("bp_after_ready1", 32'(req1_ready), 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        chk("bp_r1_data", resp_data, 32'h1);
        chk("bp_r1_id", 32'(resp_id), 32'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // Reset during EXEC discards the operation.
        req1_valid = 1'b1; req1_op = 5'd4; req1_a = 32'hF0; req1_b = 32'h0F;
        @(negedge clk);
        req1_valid = 1'b0;
        rst = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_rv", 32'(resp_valid), 32'd0);
        chk("mid_rst_data", resp_data, 32'd0);
        chk("mid_rst_alu_a", alu_a, 32'd0);
        chk("mid_rst_alu_b", alu_b, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("mid_rst_quiet%0d", c), 32'(resp_valid), 32'd0);
        end
        resp_ready = 1'b0;
        do_txn(0, 5'd1, 32'd5, 32'd3, 32'd8, 1'b0, "post_rst");

        // Random traffic against a transaction-level model.
        do_reset();
        busy = 1'b0; m_last = 1'b1; e = 0; acc_e = 0;
        m_data = '0; m_id = 1'b0; m_err = 1'b0; m_op = '0;
        for (int c = 0; c < 3000; c++) begin
            d_rst = ($urandom_range(0, 99) == 0);
            d_v0 = ($urandom_range(0, 9) < 6);
            d_v1 = ($urandom_range(0, 9) < 6);
            d_rr = $urandom_range(0, 1) == 1;
            d_a0 = $urandom; d_b0 = $urandom; d_op0 = 5'($urandom_range(0, 8));
            d_a1 = $urandom; d_b1 = $urandom; d_op1 = 5'($urandom_range(0, 8));
            rst = d_rst; resp_ready = d_rr;
            req0_valid = d_v0; req0_a = d_a0; req0_b = d_b0; req0_op = d_op0;
            req1_valid = d_v1; req1_a = d_a1; req1_b = d_b1; req1_op = d_op1;
            if (busy || d_rst)      winner = -1;
            else if (d_v0 && d_v1)  winner = m_last ? 0 : 1;
            else if (d_v0)          winner = 0;
            else if (d_v1)          winner = 1;
            else                    winner = -1;
            #1;
            chk("rnd_ready0", 32'(req0_ready), 32'(winner == 0));
            chk("rnd_ready1", 32'(req1_ready), 32'(winner == 1));
            chk("rnd_rv", 32'(resp_valid), 32'(busy && e >= acc_e + 1));
            if (busy && e >= acc_e + 1) begin
                chk("rnd_data", resp_data, m_data);
                chk("rnd_id", 32'(resp_id), 32'(m_id));
                chk("rnd_err", 32'(resp_err), 32'(m_err));
            end
            if (busy && e == acc_e) chk("rnd_alu_op", 32'(alu_op), 32'(m_op));
            @(posedge clk);
            e++;
            if (d_rst) begin
                busy = 1'b0; m_last = 1'b1;
            end else if (winner >= 0) begin
                busy   = 1'b1;
                acc_e  = e;
                m_id   = (winner == 1);
                m_last = m_id;
                m_op   = m_id ? d_op1 : d_op0;
                m_err  = m_op > 5'd6;
                m_data = m_err ? 32'd0 : (m_id ? ref_alu(d_a1, d_b1, d_op1) : ref_alu(d_a0, d_b0, d_op0));
                if (m_err) m_op = 5'd0;
            end else if (busy && e >= acc_e + 2 && d_rr) begin
                busy = 1'b0;
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
